burrito_ctrl: RTL

Multi-cycle sequencer for the register-file + ALU datapath (Burrito).
- Accepts one 32-bit R-type instruction at a time over a valid/ready handshake.
- Decodes the register addresses and the ALU operation, holds them stable for a programmable number of execute cycles, then issues a single-cycle register write.
- Sits between the instruction source (bench or future fetch unit) and the Burrito datapath inputs.

---
 rtl/burrito_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/burrito_ctrl.sv
// Multi-cycle sequencer for the Burrito register-file + ALU datapath.
// Optional statistics counters are enabled with `define BURRITO_CTRL_STATS_EN.
module burrito_ctrl #(
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic             RegWrite,
    output logic [4:0]       Addr_op1,
    output logic [4:0]       Addr_op2,
    output logic [4:0]       Addr_Destino,
    output logic [2:0]       Operacion,
    output logic             busy,
    output logic             done,
`ifdef BURRITO_CTRL_STATS_EN
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] illegal_cnt,
`endif
    output logic             illegal
);

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    typedef struct packed {
        logic       legal;
        logic [2:0] op;
    } dec_t;

    state_t      state;
    logic [31:0] instr_q;
    logic [3:0]  exec_cnt;
    dec_t        dec_in;
    dec_t        dec_q;
    logic        unused_bits;

    function automatic dec_t decode(input logic [31:0] w);
        dec_t d;
        d.legal = (w[31:26] == 6'b000000);
        d.op    = 3'b000;
        case (w[5:0])
            6'h20:   d.op = 3'b010;
            6'h22:   d.op = 3'b110;
            6'h24:   d.op = 3'b000;
            6'h25:   d.op = 3'b001;
            6'h2A:   d.op = 3'b111;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    assign dec_in = decode(instr);
    assign dec_q  = decode(instr_q);

    // Register addresses come straight from the latched word, so they hold in IDLE.
    assign Addr_op1     = instr_q[25:21];
    assign Addr_op2     = instr_q[20:16];
    assign Addr_Destino = instr_q[15:11];

    // shamt is never used by the datapath
    assign unused_bits = ^{instr_q[10:6], CNT_W > 0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            instr_q     <= '0;
            exec_cnt    <= '0;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            RegWrite    <= 1'b0;
            Operacion   <= 3'b000;
            done        <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each cycle so they can only ever last one cycle.
            RegWrite <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        instr_q     <= instr;
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                        Operacion   <= dec_in.legal ? dec_in.op : 3'b000;
                        illegal     <= !dec_in.legal;
                        state       <= DECODE;
                    end
                end
                DECODE: begin
                    if (dec_q.legal) begin
                        exec_cnt <= 4'(EXEC_CYCLES - 1);
                        state    <= EXEC;
                    end else begin
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                EXEC: begin
                    if (exec_cnt == 4'd0) begin
                        RegWrite <= (instr_q[15:11] != 5'd0);
                        done     <= 1'b1;
                        state    <= WB;
                    end else begin
                        exec_cnt <= exec_cnt - 4'd1;
                    end
                end
                WB: begin
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BURRITO_CTRL_STATS_EN
    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt <= '0;
            illegal_cnt <= '0;
        end else begin
            if (done && (retired_cnt != '1))
                retired_cnt <= retired_cnt + 1'b1;
            if (illegal && (illegal_cnt != '1))
                illegal_cnt <= illegal_cnt + 1'b1;
        end
    end
`endif

endmodule
